// File: rtl/fta_scratch_responder_if.sv
// fta_scratch_responder_if: FTA 128-bit bus request/response bundle.
// Ports: ftas_req (master->slave), ftas_resp (slave->master); modports master/slave.
package fta_pkg;
  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
    logic [7:0]   tid;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         err;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;
endpackage

interface fta_scratch_responder_if;
  import fta_pkg::*;
  fta_cmd_request128_t  ftas_req;
  fta_cmd_response128_t ftas_resp;

  modport master (output ftas_req, input ftas_resp);
  modport slave  (input ftas_req, output ftas_resp);
endinterface

// File: rtl/fta_scratch_responder.sv
// fta_scratch_responder: scratchpad RAM responder on the FTA 128-bit bus.
// Ports: clk_i, rst_i (sync, high), cs_i, bus (slave); option FTA_SCRATCH_ERR_EN.
module fta_scratch_responder
  import fta_pkg::*;
#(
  parameter logic [31:0] BASE    = 32'hFFF00000,
  parameter int          LINES   = 256,
  parameter int          LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cs_i,
  fta_scratch_responder_if.slave bus
);
  localparam int AW = $clog2(LINES * 16);
  localparam int IW = AW - 4;
  localparam logic [127:0] ID_LINE = {32'h52463836, 96'h0};

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  fta_cmd_request128_t  req;
  fta_cmd_response128_t resp_q;

  logic           we_q;
  logic [15:0]    sel_q;
  logic [IW-1:0]  idx_q;
  logic [31:0]    adr_q;
  logic [127:0]   dat_q;
  logic [7:0]     tid_q;

  logic           pend_q;
  logic [7:0]     pend_tid_q;

  logic [127:0]   mem [LINES];

  logic hit, idle, accept, busy_hit, go_ack;
  logic           e_we;
  logic [15:0]    e_sel;
  logic [IW-1:0]  e_idx;
  logic [31:0]    e_adr;
  logic [127:0]   e_dat;
  logic [7:0]     e_tid;
  logic           e_err;
  logic           id_line;

  assign req = bus.ftas_req;
  assign bus.ftas_resp = resp_q;

  assign hit = cs_i & req.cyc & req.stb
             & (req.adr[31:AW] == BASE[31:AW]);
  assign idle     = (state_q == IDLE);
  assign accept   = idle & hit;
  assign busy_hit = ~idle & hit;
  assign go_ack   = (state_d == ACK);

  // With LATENCY==1 the ack edge is the accept edge,
  // so use the live request instead of the captured copy.
  assign e_we  = idle ? req.we           : we_q;
  assign e_sel = idle ? req.sel          : sel_q;
  assign e_idx = idle ? req.adr[AW-1:4]  : idx_q;
  assign e_adr = idle ? req.adr          : adr_q;
  assign e_dat = idle ? req.dat          : dat_q;
  assign e_tid = idle ? req.tid          : tid_q;

`ifdef FTA_SCRATCH_ERR_EN
  assign id_line = (e_idx == IW'(LINES - 1));
  assign e_err   = (e_sel == 16'h0) | (e_we & id_line);
`else
  assign id_line = 1'b0;
  assign e_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (LATENCY == 1) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = ACK;
        else cnt_d = cnt_q - 3'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && go_ack && e_we && !e_err) begin
      for (int i = 0; i < 16; i++) begin
        if (e_sel[i]) mem[e_idx][8*i +: 8] <= e_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      idx_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      tid_q      <= '0;
      pend_q     <= 1'b0;
      pend_tid_q <= '0;
      resp_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= req.we;
        sel_q <= req.sel;
        idx_q <= req.adr[AW-1:4];
        adr_q <= req.adr;
        dat_q <= req.dat;
        tid_q <= req.tid;
      end
      resp_q.ack <= 1'b0;
      resp_q.rty <= 1'b0;
      resp_q.err <= 1'b0;
      if (go_ack) begin
        resp_q.ack <= 1'b1;
        resp_q.err <= e_err;
        resp_q.tid <= e_tid;
        resp_q.adr <= e_adr;
        if (e_we | e_err) resp_q.dat <= '0;
        else if (id_line) resp_q.dat <= ID_LINE;
        else resp_q.dat <= mem[e_idx];
        // ack owns this cycle; park the retry
        if (busy_hit) begin
          pend_q     <= 1'b1;
          pend_tid_q <= req.tid;
        end
      end else if (pend_q) begin
        resp_q.rty <= 1'b1;
        resp_q.tid <= pend_tid_q;
        pend_q     <= busy_hit;
        if (busy_hit) pend_tid_q <= req.tid;
      end else if (busy_hit) begin
        resp_q.rty <= 1'b1;
        resp_q.tid <= req.tid;
      end
    end
  end
endmodule
